// File: rtl/pipeline_hazard_controller_pkg.sv
// Types, defaults and helpers shared by the hazard controller and its counters.
package pipeline_hazard_controller_pkg;
`include "pipeline_ctrl_defs.vh"

    typedef enum logic [1:0] {
        ST_RUN   = `PHC_ST_RUN,
        ST_WAIT  = `PHC_ST_WAIT,
        ST_FAULT = `PHC_ST_FAULT
    } phc_state_t;

    localparam int DEF_MEM_TIMEOUT = `PHC_DEF_MEM_TIMEOUT;
    localparam int DEF_CNT_W       = `PHC_DEF_CNT_W;

    // r0 is hardwired to zero, so a load into it never creates a dependency.
    function automatic logic reg_hazard(input logic [4:0] src, input logic [4:0] dst);
        return (dst != 5'd0) && (src == dst);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_defs.vh
// Shared encodings and defaults for the pipeline hazard controller.
`ifndef PIPELINE_CTRL_DEFS_VH
`define PIPELINE_CTRL_DEFS_VH

`define PHC_ST_RUN          2'd0
`define PHC_ST_WAIT         2'd1
`define PHC_ST_FAULT        2'd2
`define PHC_DEF_MEM_TIMEOUT 64
`define PHC_DEF_CNT_W       16

`endif

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    // Count register: clear wins, then increment until all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= {W{1'b0}};
        end else if (clr) begin
            q <= {W{1'b0}};
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipe: memory wait FSM, redirect and load-use control.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt_addr,
    input  logic             ex_branch_taken,
    input  logic             ex_jump,
    input  logic             mem_access,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             fd_en,
    output logic             fd_flush,
    output logic             dx_en,
    output logic             dx_flush,
    output logic             xm_en,
    output logic             mw_bubble,
    output logic             mem_req,
    output logic             fault,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    phc_state_t      state_r, state_s;
    logic [TO_W-1:0] to_cnt_r, to_cnt_s;
    logic            freeze_s, redirect_s, loaduse_s, stall_inc_s;

    // The acknowledging WAIT cycle lets the pipe advance, so WAIT only freezes while not ready.
    always_comb begin
        case (state_r)
            ST_RUN:   freeze_s = mem_access & ~mem_ready;
            ST_WAIT:  freeze_s = ~mem_ready;
            ST_FAULT: freeze_s = 1'b1;
            default:  freeze_s = 1'b1;
        endcase
        redirect_s = ~freeze_s & (ex_branch_taken | ex_jump);
        loaduse_s  = ~freeze_s & ~redirect_s & ex_mem_read &
                     (reg_hazard(id_rs_addr, ex_rt_addr) |
                      (id_uses_rt & reg_hazard(id_rt_addr, ex_rt_addr)));
    end

    // Next-state and timeout counter.
    always_comb begin
        state_s  = state_r;
        to_cnt_s = to_cnt_r;
        case (state_r)
            ST_RUN: begin
                if (mem_access && !mem_ready) begin
                    state_s  = ST_WAIT;
                    to_cnt_s = TO_W'(1);
                end else begin
                    to_cnt_s = {TO_W{1'b0}};
                end
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    state_s  = ST_RUN;
                    to_cnt_s = {TO_W{1'b0}};
                end else if (to_cnt_r == TO_LAST) begin
                    state_s  = ST_FAULT;
                end else begin
                    to_cnt_s = to_cnt_r + TO_W'(1);
                end
            end
            ST_FAULT: state_s = ST_FAULT;
            default:  state_s = ST_FAULT;
        endcase
    end

    // FSM state, timeout count and the sticky fault flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_RUN;
            to_cnt_r <= {TO_W{1'b0}};
            fault    <= 1'b0;
        end else begin
            state_r  <= state_s;
            to_cnt_r <= to_cnt_s;
            fault    <= fault | (state_s == ST_FAULT);
        end
    end

    // Stage controls, in priority order: reset, freeze, redirect, load-use, free-run.
    always_comb begin
        pc_en     = 1'b1;
        fd_en     = 1'b1;
        fd_flush  = 1'b0;
        dx_en     = 1'b1;
        dx_flush  = 1'b0;
        xm_en     = 1'b1;
        mw_bubble = 1'b0;
        mem_req   = rst_n & mem_access & (state_r != ST_FAULT);
        if (!rst_n) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            dx_en     = 1'b0;
            xm_en     = 1'b0;
            fd_flush  = 1'b1;
            dx_flush  = 1'b1;
            mw_bubble = 1'b1;
        end else if (freeze_s) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            dx_en     = 1'b0;
            xm_en     = 1'b0;
            mw_bubble = 1'b1;
        end else if (redirect_s) begin
            fd_flush  = 1'b1;
            dx_flush  = 1'b1;
        end else if (loaduse_s) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            dx_flush  = 1'b1;
        end else begin
            pc_en     = 1'b1;
        end
    end

    assign stall_inc_s = ~pc_en;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc_s),
        .clr   (cnt_clr),
        .q     (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (redirect_s),
        .clr   (cnt_clr),
        .q     (flush_events)
    );

endmodule
